bsg_link_downstream_ch_arbiter: RTL and testbench
=================================================

BSG_LINK_DOWNSTREAM_CH_ARBITER -- requirements
Module: bsg_link_downstream_ch_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of downstream channels sharing the core port; range 2..8.
REQ-002 Parameter WIDTH, default 32: data width of each channel word.
REQ-003 Parameter TOKEN_DECIMATION, default 4: consumed words per token toggle; power of two, minimum 2.
REQ-004 Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-005 core_clk_i  input  1  sole clock; all state is updated on its rising edge.
REQ-006 core_reset_n_i  input  1  asynchronous, active-low reset.
REQ-007 ch_valid_i  input  NUM_CH  per-channel word available from the downstream FIFO.
REQ-008 ch_data_i  input  NUM_CH*WIDTH  per-channel word; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 ch_yumi_o  output  NUM_CH  one-hot dequeue strobe to the channel FIFO.
REQ-010 core_valid_o  output  1  core output register holds a word.
REQ-011 core_data_o  output  WIDTH  registered word.
REQ-012 core_ch_id_o  output  clog2(NUM_CH)  source channel of core_data_o.
REQ-013 core_yumi_i  input  1  core consumes the current word.
REQ-014 core_token_r_o  output  NUM_CH  per-channel credit token, returned to the upstream by toggling.
REQ-015 ch_word_cnt_o  output  NUM_CH*16  per-channel consumed-word count; present only with BSG_LINK_ARB_STATS_EN.

Function
REQ-016 The output register is "free" when core_valid_o=0, or when core_valid_o=1 and core_yumi_i=1.
REQ-017 In a free cycle with at least one ch_valid_i set, the arbiter grants one channel.
  - Asserts ch_yumi_o for that channel in the same cycle.
  - Loads core_data_o and core_ch_id_o at the next edge.
  - Sets core_valid_o at the next edge.
REQ-018 Grant order is round-robin: search starts at last_grant+1 modulo NUM_CH, lowest index first from that point.
REQ-019 last_grant updates only on an issued grant.
REQ-020 Latency from ch_valid_i to core_valid_o is 1 cycle; sustained throughput is 1 word/cycle with core_yumi_i held high.
REQ-021 Stall: when the register is not free, ch_yumi_o is all-zero and core_data_o/core_ch_id_o hold stable.
REQ-022 Drain: if the register is free and no channel is valid, core_valid_o clears at the next edge.
REQ-023 ch_yumi_o is at most one-hot and is never asserted to a channel whose ch_valid_i is 0.
REQ-024 core_yumi_i while core_valid_o=0 is illegal and is ignored: no counter or token changes.
REQ-025 Token counters: one clog2(TOKEN_DECIMATION)-bit counter per channel.
  - Increments on core_valid_o & core_yumi_i when core_ch_id_o equals that channel.
  - On wrap from TOKEN_DECIMATION-1 to 0, the channel's core_token_r_o toggles at the same edge.
REQ-026 Simultaneous consume and grant in the same cycle are both honoured: token update for the leaving word, load of the new word.
REQ-027 A single persistent requester is granted back-to-back every free cycle.

Reset
REQ-028 Asserting core_reset_n_i low immediately forces all outputs to the reset state, independent of the clock:
  - core_valid_o=0, core_data_o=0, core_ch_id_o=0.
  - ch_yumi_o=0, core_token_r_o=0, ch_word_cnt_o=0.
  - all token counters=0.
  - last_grant=NUM_CH-1, so channel 0 has first priority.
REQ-029 Reset mid-transfer discards the registered word; no token is credited for it.
REQ-030 The first grant is possible in the first clock edge after core_reset_n_i deasserts.

Configuration
REQ-031 With BSG_LINK_ARB_STATS_EN defined:
  - ch_word_cnt_o exists.
  - Each 16-bit field counts consumed words of its channel.
  - Each field saturates at 16'hFFFF.
REQ-032 Without BSG_LINK_ARB_STATS_EN: the port and its counters are absent; all other behaviour is identical.

Verification
REQ-033 Reset then ch_valid_i=2'b11 with core_yumi_i=1 for 6 cycles -> ch_yumi_o sequence 01,10,01,10,01,10; core_ch_id_o 0,1,0,1,0,1 one cycle later.
REQ-034 Only channel 1 valid with data 0xA5A5_0000..0xA5A5_0007, core_yumi_i=1 -> 8 consecutive words in order; core_token_r_o[1] toggles after word 4 and again after word 8 (0->1->0).
REQ-035 Word 0xDEAD_BEEF loaded, core_yumi_i=0 for 5 cycles while both channels valid -> core_data_o stays 0xDEAD_BEEF; ch_yumi_o=0 throughout; on yumi, the next grant goes to the other channel.
REQ-036 core_reset_n_i pulsed low between clock edges while core_valid_o=1 -> outputs are zero before the next edge; token counters restart; the first post-reset grant goes to channel 0.
REQ-037 With BSG_LINK_ARB_STATS_EN, 70000 consumes on channel 0 -> ch_word_cnt_o[15:0]=16'hFFFF, channel 1 field=0; a build without the macro has no ch_word_cnt_o port.
REQ-038 core_yumi_i=1 with core_valid_o=0 for 3 cycles -> token outputs, counters and last_grant are unchanged.

Source files
------------

// File: rtl/bsg_link_downstream_ch_arbiter_if.sv
// Channel-to-core handshake bundle for the downstream channel arbiter.
// The ch_word_cnt_o statistics field is present only when BSG_LINK_ARB_STATS_EN is defined.
interface bsg_link_downstream_ch_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 32
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       ch_valid_i;
  logic [NUM_CH*WIDTH-1:0] ch_data_i;
  logic [NUM_CH-1:0]       ch_yumi_o;
  logic                    core_valid_o;
  logic [WIDTH-1:0]        core_data_o;
  logic [ID_W-1:0]         core_ch_id_o;
  logic                    core_yumi_i;
  logic [NUM_CH-1:0]       core_token_r_o;
`ifdef BSG_LINK_ARB_STATS_EN
  logic [NUM_CH*16-1:0]    ch_word_cnt_o;
`endif

  modport slave (
    input  ch_valid_i,
    input  ch_data_i,
    input  core_yumi_i,
    output ch_yumi_o,
    output core_valid_o,
    output core_data_o,
    output core_ch_id_o,
`ifdef BSG_LINK_ARB_STATS_EN
    output ch_word_cnt_o,
`endif
    output core_token_r_o
  );

  modport master (
    output ch_valid_i,
    output ch_data_i,
    output core_yumi_i,
    input  ch_yumi_o,
    input  core_valid_o,
    input  core_data_o,
    input  core_ch_id_o,
`ifdef BSG_LINK_ARB_STATS_EN
    input  ch_word_cnt_o,
`endif
    input  core_token_r_o
  );
endinterface

// File: rtl/bsg_link_downstream_ch_arbiter.sv
// Round-robin merge of NUM_CH downstream channel FIFOs into one registered core port,
// with per-channel decimated credit tokens. Define BSG_LINK_ARB_STATS_EN for per-channel word counters.
module bsg_link_downstream_ch_arbiter #(
  parameter int NUM_CH           = 2,
  parameter int WIDTH            = 32,
  parameter int TOKEN_DECIMATION = 4
) (
  input logic                               core_clk_i,
  input logic                               core_reset_n_i,
  bsg_link_downstream_ch_arbiter_if.slave   link
);
  localparam int ID_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TOKEN_DECIMATION);
  localparam logic [ID_W-1:0]  LAST_CH  = ID_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] TOK_WRAP = CNT_W'(TOKEN_DECIMATION - 1);

  logic              vld_p1;
  logic [WIDTH-1:0]  data_p1;
  logic [ID_W-1:0]   ch_id_p1;
  logic [ID_W-1:0]   last_grant;
  logic [NUM_CH-1:0] token_r;
  logic [CNT_W-1:0]  tok_cnt [NUM_CH];

  logic              free;
  logic              consume;
  logic              take;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [WIDTH-1:0]  grant_data;
  logic [NUM_CH-1:0] yumi;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- p0: free test and round-robin grant selection ----
  assign consume = vld_p1 & link.core_yumi_i;
  assign free    = ~vld_p1 | link.core_yumi_i;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      logic [ID_W-1:0] sel;
      sel = ID_W'((int'(last_grant) + i) % NUM_CH);
      if (!grant_vld && link.ch_valid_i[sel]) begin
        grant_vld = 1'b1;
        grant_id  = sel;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_id == ID_W'(k)) grant_data = link.ch_data_i[k*WIDTH +: WIDTH];
    end
  end

  // Gated by reset so no FIFO is dequeued while the output register is held clear.
  assign take = core_reset_n_i & free & grant_vld;

  always_comb begin
    yumi = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      yumi[k] = take && (grant_id == ID_W'(k));
    end
  end

  // ---- p1: core output register ----
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      ch_id_p1   <= '0;
      last_grant <= LAST_CH;
    end else if (free) begin
      vld_p1 <= grant_vld;
      if (grant_vld) begin
        data_p1    <= grant_data;
        ch_id_p1   <= grant_id;
        last_grant <= grant_id;
      end
    end
  end

  // Credit for the word leaving p1; a grant in the same cycle does not interfere.
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      token_r <= '0;
      for (int k = 0; k < NUM_CH; k++) tok_cnt[k] <= '0;
    end else if (consume) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_id_p1 == ID_W'(k)) begin
          tok_cnt[k] <= tok_cnt[k] + 1'b1;
          if (tok_cnt[k] == TOK_WRAP) token_r[k] <= ~token_r[k];
        end
      end
    end
  end

`ifdef BSG_LINK_ARB_STATS_EN
  logic [15:0] word_cnt [NUM_CH];

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      for (int k = 0; k < NUM_CH; k++) word_cnt[k] <= '0;
    end else if (consume) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_id_p1 == ID_W'(k)) word_cnt[k] <= sat_inc16(word_cnt[k]);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stats
    assign link.ch_word_cnt_o[g*16 +: 16] = word_cnt[g];
  end
`endif

  assign link.ch_yumi_o      = yumi;
  assign link.core_valid_o   = vld_p1;
  assign link.core_data_o    = data_p1;
  assign link.core_ch_id_o   = ch_id_p1;
  assign link.core_token_r_o = token_r;
endmodule

// File: tb/tb_bsg_link_downstream_ch_arbiter.sv
// Directed bench for bsg_link_downstream_ch_arbiter (NUM_CH=2, WIDTH=32, TOKEN_DECIMATION=4).
module tb_bsg_link_downstream_ch_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  bsg_link_downstream_ch_arbiter_if #(.NUM_CH(2), .WIDTH(32)) link();

  bsg_link_downstream_ch_arbiter #(.NUM_CH(2), .WIDTH(32), .TOKEN_DECIMATION(4)) u_dut (
    .core_clk_i     (clk),
    .core_reset_n_i (rst_n),
    .link           (link)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 3 time units after a rising edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    link.ch_valid_i  = '0;
    link.ch_data_i   = '0;
    link.core_yumi_i = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    link.ch_valid_i  = 2'b11;
    link.ch_data_i   = 64'h1234_5678_9ABC_DEF0;
    link.core_yumi_i = 1'b1;
    tick();
    tick();
    checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", link.core_valid_o); end
    checks++; if (link.core_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", link.core_data_o); end
    checks++; if (link.core_ch_id_o !== 1'b0) begin errors++; $display("FAIL reset_id got %b want 0", link.core_ch_id_o); end
    checks++; if (link.ch_yumi_o !== 2'b00) begin errors++; $display("FAIL reset_yumi got %b want 00", link.ch_yumi_o); end
    checks++; if (link.core_token_r_o !== 2'b00) begin errors++; $display("FAIL reset_token got %b want 00", link.core_token_r_o); end
    link.ch_valid_i  = '0;
    link.core_yumi_i = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    do_reset();
    link.ch_data_i   = {32'h0000_00C1, 32'h0000_00C0};
    link.ch_valid_i  = 2'b11;
    link.core_yumi_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [1:0]  exp_yumi;
      logic [31:0] exp_data;
      exp_yumi = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (k % 2 == 0) ? 32'h0000_00C0 : 32'h0000_00C1;
      #1;
      checks++; if (link.ch_yumi_o !== exp_yumi) begin errors++; $display("FAIL rr_yumi k=%0d got %b want %b", k, link.ch_yumi_o, exp_yumi); end
      tick();
      checks++; if (link.core_valid_o !== 1'b1) begin errors++; $display("FAIL rr_valid k=%0d got %b want 1", k, link.core_valid_o); end
      checks++; if (link.core_ch_id_o !== 1'(k % 2)) begin errors++; $display("FAIL rr_id k=%0d got %b want %0d", k, link.core_ch_id_o, k % 2); end
      checks++; if (link.core_data_o !== exp_data) begin errors++; $display("FAIL rr_data k=%0d got %h want %h", k, link.core_data_o, exp_data); end
    end
    link.ch_valid_i = 2'b00;
    tick();
    checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", link.core_valid_o); end
    checks++; if (link.core_token_r_o !== 2'b00) begin errors++; $display("FAIL rr_token got %b want 00", link.core_token_r_o); end
  endtask

  task automatic test_single_channel();
    do_reset();
    link.ch_valid_i  = 2'b10;
    link.core_yumi_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      logic [1:0] exp_tok;
      link.ch_data_i[63:32] = 32'hA5A5_0000 + 32'(n);
      #1;
      checks++; if (link.ch_yumi_o !== 2'b10) begin errors++; $display("FAIL single_yumi n=%0d got %b want 10", n, link.ch_yumi_o); end
      tick();
      exp_tok = (n >= 4) ? 2'b10 : 2'b00;
      checks++; if (link.core_data_o !== 32'hA5A5_0000 + 32'(n)) begin errors++; $display("FAIL single_data n=%0d got %h want %h", n, link.core_data_o, 32'hA5A5_0000 + 32'(n)); end
      checks++; if (link.core_ch_id_o !== 1'b1) begin errors++; $display("FAIL single_id n=%0d got %b want 1", n, link.core_ch_id_o); end
      checks++; if (link.core_token_r_o !== exp_tok) begin errors++; $display("FAIL single_token n=%0d got %b want %b", n, link.core_token_r_o, exp_tok); end
    end
    link.ch_valid_i = 2'b00;
    tick();
    checks++; if (link.core_token_r_o !== 2'b00) begin errors++; $display("FAIL single_token_8 got %b want 00", link.core_token_r_o); end
    checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", link.core_valid_o); end
  endtask

  task automatic test_stall();
    link.ch_valid_i       = 2'b01;
    link.ch_data_i[31:0]  = 32'hDEAD_BEEF;
    link.core_yumi_i      = 1'b0;
    tick();
    checks++; if (link.core_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_load got %h want deadbeef", link.core_data_o); end
    link.ch_valid_i = 2'b11;
    link.ch_data_i  = {32'h2222_2222, 32'h1111_1111};
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (link.ch_yumi_o !== 2'b00) begin errors++; $display("FAIL stall_yumi c=%0d got %b want 00", c, link.ch_yumi_o); end
      tick();
      checks++; if (link.core_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_data c=%0d got %h want deadbeef", c, link.core_data_o); end
      checks++; if (link.core_ch_id_o !== 1'b0 || link.core_valid_o !== 1'b1) begin errors++; $display("FAIL stall_hold c=%0d got id %b valid %b want id 0 valid 1", c, link.core_ch_id_o, link.core_valid_o); end
    end
    link.core_yumi_i = 1'b1;
    #1;
    checks++; if (link.ch_yumi_o !== 2'b10) begin errors++; $display("FAIL stall_next_yumi got %b want 10", link.ch_yumi_o); end
    tick();
    checks++; if (link.core_ch_id_o !== 1'b1 || link.core_data_o !== 32'h2222_2222) begin errors++; $display("FAIL stall_next got id %b data %h want id 1 data 22222222", link.core_ch_id_o, link.core_data_o); end
    link.ch_valid_i = 2'b00;
    tick();
    link.core_yumi_i = 1'b0;
  endtask

  task automatic test_illegal_yumi();
    do_reset();
    link.ch_valid_i  = 2'b00;
    link.core_yumi_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (link.core_valid_o !== 1'b0 || link.core_token_r_o !== 2'b00) begin errors++; $display("FAIL illegal_idle c=%0d got valid %b token %b want 0 00", c, link.core_valid_o, link.core_token_r_o); end
    end
    link.ch_valid_i = 2'b11;
    #1;
    checks++; if (link.ch_yumi_o !== 2'b01) begin errors++; $display("FAIL illegal_priority got %b want 01", link.ch_yumi_o); end
    for (int j = 1; j <= 5; j++) begin
      logic [1:0] exp_tok;
      tick();
      link.ch_valid_i = 2'b01;
      exp_tok = (j >= 5) ? 2'b01 : 2'b00;
      checks++; if (link.core_token_r_o !== exp_tok) begin errors++; $display("FAIL illegal_token j=%0d got %b want %b", j, link.core_token_r_o, exp_tok); end
    end
  endtask

  // Continues from test_illegal_yumi: channel 0 streaming, four words already credited.
  task automatic test_async_reset();
    tick();
    tick();
    checks++; if (link.core_token_r_o !== 2'b01 || link.core_valid_o !== 1'b1) begin errors++; $display("FAIL areset_pre got token %b valid %b want 01 1", link.core_token_r_o, link.core_valid_o); end
    #2 rst_n = 1'b0;
    link.ch_valid_i = 2'b11;
    #1;
    checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", link.core_valid_o); end
    checks++; if (link.core_data_o !== 32'h0 || link.core_ch_id_o !== 1'b0) begin errors++; $display("FAIL areset_data got %h id %b want 0 0", link.core_data_o, link.core_ch_id_o); end
    checks++; if (link.core_token_r_o !== 2'b00) begin errors++; $display("FAIL areset_token got %b want 00", link.core_token_r_o); end
    checks++; if (link.ch_yumi_o !== 2'b00) begin errors++; $display("FAIL areset_yumi got %b want 00", link.ch_yumi_o); end
    #1 rst_n = 1'b1;
    #1;
    checks++; if (link.ch_yumi_o !== 2'b01) begin errors++; $display("FAIL areset_first_grant got %b want 01", link.ch_yumi_o); end
    for (int j = 1; j <= 5; j++) begin
      logic [1:0] exp_tok;
      tick();
      link.ch_valid_i = 2'b01;
      exp_tok = (j >= 5) ? 2'b01 : 2'b00;
      checks++; if (link.core_ch_id_o !== 1'b0) begin errors++; $display("FAIL areset_id j=%0d got %b want 0", j, link.core_ch_id_o); end
      checks++; if (link.core_token_r_o !== exp_tok) begin errors++; $display("FAIL areset_token j=%0d got %b want %b", j, link.core_token_r_o, exp_tok); end
    end
    link.ch_valid_i  = 2'b00;
    link.core_yumi_i = 1'b0;
  endtask

`ifdef BSG_LINK_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    link.ch_valid_i  = 2'b01;
    link.core_yumi_i = 1'b1;
    for (int c = 0; c < 70001; c++) tick();
    checks++; if (link.ch_word_cnt_o[15:0] !== 16'hFFFF) begin errors++; $display("FAIL stats_ch0 got %h want ffff", link.ch_word_cnt_o[15:0]); end
    checks++; if (link.ch_word_cnt_o[31:16] !== 16'h0000) begin errors++; $display("FAIL stats_ch1 got %h want 0000", link.ch_word_cnt_o[31:16]); end
    link.ch_valid_i  = 2'b00;
    link.core_yumi_i = 1'b0;
  endtask
`endif

  initial begin
    link.ch_valid_i  = '0;
    link.ch_data_i   = '0;
    link.core_yumi_i = 1'b0;
    test_reset();
    test_round_robin();
    test_single_channel();
    test_stall();
    test_illegal_yumi();
    test_async_reset();
`ifdef BSG_LINK_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
